// File: rtl/hp_div.sv
// hp_div - sequential IEEE 754 binary16 divider, p = a / b.
//
// Decodes both operands on capture, resolves special operands immediately,
// then normalises subnormal significands (NORM), runs a restoring divider
// (DIV) and packs the quotient with range handling (PACK).
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   operand handshake; in_ready is high only when idle
//   a, b                  dividend / divisor, binary16
//   out_valid / out_ready result handshake
//   p                     quotient, binary16
//   Snan .. Subnormal     one-hot class of p, valid while out_valid is high
//
// Build option: define HP_DIV_RNE_EN for 13 iterations with round to nearest,
// ties to even; otherwise 12 iterations with truncation toward zero.
module hp_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] p,
   output logic        Snan,
   output logic        Qnan,
   output logic        Inf,
   output logic        Zero,
   output logic        Normal,
   output logic        Subnormal
);
`ifdef HP_DIV_RNE_EN
   localparam int N = 13;
`else
   localparam int N = 12;
`endif

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_NORM = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_PACK = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // Flag vector order: {Snan, Qnan, Inf, Zero, Normal, Subnormal}
   localparam logic [5:0] F_SNAN = 6'b100000;
   localparam logic [5:0] F_QNAN = 6'b010000;
   localparam logic [5:0] F_INF  = 6'b001000;
   localparam logic [5:0] F_ZERO = 6'b000100;
   localparam logic [5:0] F_NORM = 6'b000010;
   localparam logic [5:0] F_SUB  = 6'b000001;

   logic [2:0]        state_q, state_d;
   logic              sign_q, sign_d;
   logic signed [6:0] ea_q, ea_d, eb_q, eb_d;
   logic [10:0]       as_q, as_d, bs_q, bs_d;
   logic [11:0]       r_q, r_d;
   logic [N-1:0]      q_q, q_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       p_q, p_d;
   logic [5:0]        flags_q, flags_d;

   // Operand decode
   logic a_max, b_max, a_nan, b_nan, a_snan, b_snan, a_qnan, b_qnan;
   logic a_inf, b_inf, a_zero, b_zero;
   logic signed [6:0] a_exp, b_exp;
   logic [10:0]       a_sig, b_sig;

   assign a_max  = (a[14:10] == 5'h1F);
   assign b_max  = (b[14:10] == 5'h1F);
   assign a_nan  = a_max & (a[9:0] != 10'h0);
   assign b_nan  = b_max & (b[9:0] != 10'h0);
   assign a_snan = a_nan & ~a[9];
   assign b_snan = b_nan & ~b[9];
   assign a_qnan = a_nan & a[9];
   assign b_qnan = b_nan & b[9];
   assign a_inf  = a_max & (a[9:0] == 10'h0);
   assign b_inf  = b_max & (b[9:0] == 10'h0);
   assign a_zero = (a[14:0] == 15'h0);
   assign b_zero = (b[14:0] == 15'h0);
   assign a_exp  = (a[14:10] == 5'h00) ? -7'sd14 : $signed({2'b00, a[14:10]}) - 7'sd15;
   assign b_exp  = (b[14:10] == 5'h00) ? -7'sd14 : $signed({2'b00, b[14:10]}) - 7'sd15;
   assign a_sig  = {a[14:10] != 5'h00, a[9:0]};
   assign b_sig  = {b[14:10] != 5'h00, b[9:0]};

   // One normalisation step: only significands without the hidden bit move
   logic [10:0]       as_n, bs_n;
   logic signed [6:0] ea_n, eb_n;
   always_comb begin
      as_n = as_q[10] ? as_q : {as_q[9:0], 1'b0};
      bs_n = bs_q[10] ? bs_q : {bs_q[9:0], 1'b0};
      ea_n = as_q[10] ? ea_q : ea_q - 7'sd1;
      eb_n = bs_q[10] ? eb_q : eb_q - 7'sd1;
   end

   // One restoring division step
   logic        q_bit;
   logic [11:0] r_sub;
   always_comb begin
      q_bit = (r_q >= {1'b0, bs_q});
      r_sub = q_bit ? (r_q - {1'b0, bs_q}) : r_q;
   end

   // Pack: exponent/significand selection, optional rounding, range handling
   logic signed [6:0] e_pk;
   logic [10:0]       sig_pk, sub_pk;
   logic [6:0]        sh;
   logic [4:0]        e_field;
   logic [15:0]       pack_p;
   logic [5:0]        pack_flags;
`ifdef HP_DIV_RNE_EN
   logic        guard, sticky, lost;
   logic [11:0] ext_pk, ext_sh;
`endif
   always_comb begin
      e_pk = ea_q - eb_q;
      if (q_q[N-1]) begin
         sig_pk = q_q[N-1 -: 11];
      end else begin
         sig_pk = q_q[N-2 -: 11];
         e_pk   = e_pk - 7'sd1;
      end
`ifdef HP_DIV_RNE_EN
      if (q_q[N-1]) begin
         guard  = q_q[1];
         sticky = q_q[0] | (r_q != 12'h0);
      end else begin
         guard  = q_q[0];
         sticky = (r_q != 12'h0);
      end
      // Rounding in the normal range; a carry out renormalises to 1.0 * 2^(e+1)
      if ((e_pk >= -7'sd14) && guard && (sticky || sig_pk[0])) begin
         if (sig_pk == 11'h7FF) begin
            sig_pk = 11'h400;
            e_pk   = e_pk + 7'sd1;
         end else begin
            sig_pk = sig_pk + 11'd1;
         end
      end
`endif
      sh      = -7'sd14 - e_pk;
      e_field = e_pk[4:0] + 5'd15;
`ifdef HP_DIV_RNE_EN
      // Subnormals round at the shifted position; shifted-out bits join sticky
      ext_pk = {sig_pk, guard};
      lost   = ((ext_pk & ((12'h001 << sh) - 12'h001)) != 12'h000);
      ext_sh = ext_pk >> sh;
      sub_pk = ext_sh[11:1] + {10'h0, ext_sh[0] & (sticky | lost | ext_sh[1])};
`else
      sub_pk = sig_pk >> sh;
`endif
      pack_p     = {sign_q, 15'h0};
      pack_flags = F_ZERO;
      if (e_pk > 7'sd15) begin
         pack_p     = {sign_q, 5'h1F, 10'h000};
         pack_flags = F_INF;
      end else if (e_pk < -7'sd24) begin
         pack_p     = {sign_q, 15'h0};
         pack_flags = F_ZERO;
      end else if (e_pk < -7'sd14) begin
         // sub_pk[10] can only be set by rounding up into the smallest normal
         if (sub_pk != 11'h0) begin
            pack_p     = {sign_q, 4'h0, sub_pk};
            pack_flags = sub_pk[10] ? F_NORM : F_SUB;
         end
      end else begin
         pack_p     = {sign_q, e_field, sig_pk[9:0]};
         pack_flags = F_NORM;
      end
   end

   // Control FSM
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      ea_d    = ea_q;
      eb_d    = eb_q;
      as_d    = as_q;
      bs_d    = bs_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d = a[15] ^ b[15];
               ea_d   = a_exp;
               eb_d   = b_exp;
               as_d   = a_sig;
               bs_d   = b_sig;
               r_d    = {1'b0, a_sig};
               q_d    = '0;
               cnt_d  = 4'd0;
               state_d = S_DONE;
               if (a_snan) begin
                  p_d = a;  flags_d = F_SNAN;
               end else if (b_snan) begin
                  p_d = b;  flags_d = F_SNAN;
               end else if (a_qnan) begin
                  p_d = a;  flags_d = F_QNAN;
               end else if (b_qnan) begin
                  p_d = b;  flags_d = F_QNAN;
               end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
                  p_d = {a[15] ^ b[15], 6'b111111, 9'h000};  flags_d = F_QNAN;
               end else if (a_inf || b_zero) begin
                  p_d = {a[15] ^ b[15], 5'h1F, 10'h000};  flags_d = F_INF;
               end else if (a_zero || b_inf) begin
                  p_d = {a[15] ^ b[15], 15'h0000};  flags_d = F_ZERO;
               end else if (a_sig[10] && b_sig[10]) begin
                  state_d = S_DIV;
               end else begin
                  state_d = S_NORM;
               end
            end
         end
         S_NORM: begin
            as_d = as_n;
            bs_d = bs_n;
            ea_d = ea_n;
            eb_d = eb_n;
            // Leave as soon as the step just taken normalises both operands
            if (as_n[10] && bs_n[10]) begin
               r_d     = {1'b0, as_n};
               q_d     = '0;
               cnt_d   = 4'd0;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            // r_sub < bSig, so the doubled remainder still fits in 12 bits
            r_d   = r_sub << 1;
            q_d   = {q_q[N-2:0], q_bit};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(N - 1)) state_d = S_PACK;
         end
         S_PACK: begin
            p_d     = pack_p;
            flags_d = pack_flags;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sign_q  <= 1'b0;
         ea_q    <= '0;
         eb_q    <= '0;
         as_q    <= '0;
         bs_q    <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         ea_q    <= ea_d;
         eb_q    <= eb_d;
         as_q    <= as_d;
         bs_q    <= bs_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign p         = p_q;
   assign {Snan, Qnan, Inf, Zero, Normal, Subnormal} = flags_q;
endmodule

// File: tb/tb_hp_div.sv
// tb_hp_div - self-checking bench for hp_div (default truncating build).
// The reference quotient is the largest binary16 magnitude not exceeding the
// exact rational a/b (found by binary search over encodings), with Inf once
// the exact quotient reaches 2^16; special operands follow the class rules.
module tb_hp_div;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_i, b_i;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p_o;
   logic [5:0]  flags_o;   // {Snan, Qnan, Inf, Zero, Normal, Subnormal}

   localparam logic [5:0] F_SNAN = 6'b100000;
   localparam logic [5:0] F_QNAN = 6'b010000;
   localparam logic [5:0] F_INF  = 6'b001000;
   localparam logic [5:0] F_ZERO = 6'b000100;
   localparam logic [5:0] F_NORM = 6'b000010;
   localparam logic [5:0] F_SUB  = 6'b000001;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   hp_div dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a_i), .b(b_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .p(p_o),
      .Snan(flags_o[5]), .Qnan(flags_o[4]), .Inf(flags_o[3]),
      .Zero(flags_o[2]), .Normal(flags_o[1]), .Subnormal(flags_o[0])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Magnitude of an encoding is mant * 2^expo
   function automatic longint unsigned mant(input logic [15:0] v);
      longint unsigned m;
      m = longint'(v[9:0]);
      if (v[14:10] != 5'h00) m = m + 1024;
      return m;
   endfunction

   function automatic int expo(input logic [15:0] v);
      if (v[14:10] == 5'h00) return -24;
      return int'(v[14:10]) - 25;
   endfunction

   // |x| <= |na| / |nb| ?
   function automatic bit leq(input logic [15:0] x, input logic [15:0] na, input logic [15:0] nb);
      longint unsigned l, r;
      int d;
      l = mant(x) * mant(nb);
      r = mant(na);
      d = expo(x) + expo(nb) - expo(na);
      if (l == 0) return 1'b1;
      if (d > 0) begin
         if (d > 30) return 1'b0;
         l = l << d;
      end else if (d < 0) begin
         if (d < -40) return 1'b1;
         r = r << (-d);
      end
      return (l <= r);
   endfunction

   function automatic int lz(input logic [15:0] v);
      longint unsigned m;
      int n;
      m = mant(v);
      n = 0;
      while (m < 1024 && n < 11) begin
         m = m << 1;
         n++;
      end
      return n;
   endfunction

   task automatic model(input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] ep, output logic [5:0] ef, output int elat);
      logic s;
      bit xn, yn, xsn, ysn, xqn, yqn, xi, yi, xz, yz;
      int lo, hi, mid;
      logic [15:0] cand;
      s   = x[15] ^ y[15];
      xn  = (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
      yn  = (y[14:10] == 5'h1F) && (y[9:0] != 10'h0);
      xsn = xn && !x[9];
      ysn = yn && !y[9];
      xqn = xn && x[9];
      yqn = yn && y[9];
      xi  = (x[14:0] == 15'h7C00);
      yi  = (y[14:0] == 15'h7C00);
      xz  = (x[14:0] == 15'h0);
      yz  = (y[14:0] == 15'h0);
      elat = 1;
      if (xsn)      begin ep = x; ef = F_SNAN; end
      else if (ysn) begin ep = y; ef = F_SNAN; end
      else if (xqn) begin ep = x; ef = F_QNAN; end
      else if (yqn) begin ep = y; ef = F_QNAN; end
      else if ((xi && yi) || (xz && yz)) begin ep = {s, 15'h7E00}; ef = F_QNAN; end
      else if (xi || yz) begin ep = {s, 15'h7C00}; ef = F_INF; end
      else if (xz || yi) begin ep = {s, 15'h0000}; ef = F_ZERO; end
      else begin
         lo = 0;
         hi = 32'h7C00;
         while (lo < hi) begin
            mid  = (lo + hi + 1) / 2;
            cand = mid[15:0];
            if (leq(cand, x, y)) lo = mid;
            else hi = mid - 1;
         end
         cand = lo[15:0];
         ep   = {s, cand[14:0]};
         if (cand == 16'h0)              ef = F_ZERO;
         else if (cand == 16'h7C00)      ef = F_INF;
         else if (cand[14:10] == 5'h00)  ef = F_SUB;
         else                            ef = F_NORM;
         elat = 1 + ((lz(x) > lz(y)) ? lz(x) : lz(y)) + 12 + 1;
      end
   endtask

   // One transaction: offer operands, time the result, check it, optionally
   // stall the consumer for `hold` cycles, then complete the handshake.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input int hold, input bit early);
      logic [15:0] ep;
      logic [5:0]  ef;
      int elat, lat;
      model(ta, tbv, ep, ef, elat);
      a_i = ta;
      b_i = tbv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      a_i       = 16'($urandom);
      b_i       = 16'($urandom);
      out_ready = early;
      lat = 1;
      check("busy_in_ready", in_ready, 1'b0);
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("out_valid", out_valid, 1'b1);
      check("latency", lat, elat);
      check("p", p_o, ep);
      check("flags", flags_o, ef);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1'b1);
         check("hold_p", p_o, ep);
         check("hold_flags", flags_o, ef);
         check("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_in_ready", in_ready, 1'b1);
      check("release_valid", out_valid, 1'b0);
      $display("[TB] a=%h b=%h p=%h flags=%b latency=%0d expected p=%h flags=%b latency=%0d",
               ta, tbv, ep, ef, lat, ep, ef, elat);
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_i       = 16'h0;
      b_i       = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_p", p_o, 16'h0000);
      check("reset_flags", flags_o, 6'b000000);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      do_op(16'h4200, 16'h3E00, 0, 1'b0);   // 3.0 / 1.5 = 2.0
      check("dir_3_div_1p5", p_o, 16'h4000);
      do_op(16'h3C00, 16'h4200, 0, 1'b0);   // 1/3 truncated
      do_op(16'h0400, 16'h4000, 0, 1'b0);   // subnormal result
      do_op(16'h0001, 16'h0001, 0, 1'b0);   // NORM runs 10 cycles
      do_op(16'h3C00, 16'h0000, 0, 1'b0);   // x/0 -> Inf
      do_op(16'h0000, 16'h0000, 0, 1'b0);   // 0/0 -> qNaN
      do_op(16'h7D00, 16'h3C00, 0, 1'b0);   // sNaN passes through
      do_op(16'h3C00, 16'h7E01, 0, 1'b0);   // qNaN divisor
      do_op(16'hFC00, 16'h7C00, 0, 1'b0);   // Inf/Inf -> qNaN, negative
      do_op(16'h7BFF, 16'h0001, 0, 1'b0);   // overflow -> Inf
      do_op(16'h0001, 16'h7BFF, 0, 1'b0);   // underflow -> Zero
      do_op(16'hC500, 16'h3E00, 5, 1'b0);   // consumer stalls 5 cycles
      do_op(16'h4400, 16'h4000, 0, 1'b1);   // out_ready high early

      // Reset in the middle of DIV
      a_i = 16'h4200;
      b_i = 16'h3E00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_busy", in_ready, 1'b0);
      rst = 1'b1;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_p", p_o, 16'h0000);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_flags", flags_o, 6'b000000);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(16'h4200, 16'h3E00, 0, 1'b0);

      // Randomised operands, a quarter forced subnormal per operand
      for (int n = 0; n < 40; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 3) == 0) ra[14:10] = 5'h00;
         if ($urandom_range(0, 3) == 0) rb[14:10] = 5'h00;
         if ($urandom_range(0, 3) == 0) do_op(ra, rb, 0, 1'b1);
         else do_op(ra, rb, $urandom_range(0, 2), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
